// File: rtl/imem_refill_bridge.sv
// Instruction-side cache line refill engine.
// On a miss the whole line containing the missing address is read from RAM,
// critical word first with wrap-around inside the line, one outstanding read
// at a time. Each returned word is handed to the cache controller as a
// one-cycle word_ready pulse together with its index in the line.
module imem_refill_bridge #(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          miss_req,
    input  logic [ADDR_W-1:0]             miss_addr,
    output logic [WORD_W-1:0]             mem_word,
    output logic                          word_ready,
    output logic [$clog2(LINE_WORDS)-1:0] word_idx,
    output logic                          refill_done,
    output logic                          busy,
    output logic                          ram_req,
    output logic [ADDR_W-1:0]             ram_addr,
    input  logic                          ram_gnt,
    input  logic [WORD_W-1:0]             ram_rdata,
    input  logic                          ram_rvalid
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF   = $clog2(LINE_WORDS * 4);

    // Byte-offset bits of a line; cleared to form the line base address.
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
    // Value of cnt_q while the last word of the line is outstanding.
    localparam logic [IDX_W-1:0]  LAST_CNT  = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  base_q;
    logic [IDX_W-1:0]   start_q;
    logic [IDX_W-1:0]   cnt_q;

    logic [ADDR_W-1:0]  miss_base_s;
    logic [IDX_W-1:0]   miss_start_s;
    logic [IDX_W-1:0]   cur_idx_s;
    logic [IDX_W-1:0]   cnt_d;
    logic [IDX_W-1:0]   next_idx_s;

    // Word address inside the line; the index wraps naturally in IDX_W bits,
    // so the upper address bits (the base) never change during a refill.
    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [ADDR_W-1:0] base,
        input logic [IDX_W-1:0]  idx
    );
        return base | ADDR_W'({idx, 2'b00});
    endfunction

    // Line base/start of an incoming miss and the wrapped indices of the
    // word in flight and of the following word.
    always_comb begin
        miss_base_s  = miss_addr & ~LINE_MASK;
        miss_start_s = miss_addr[OFF-1:2];
        cur_idx_s    = start_q + cnt_q;
        cnt_d        = cnt_q + {{(IDX_W-1){1'b0}}, 1'b1};
        next_idx_s   = start_q + cnt_d;
    end

    // Refill FSM with all outputs registered.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            base_q      <= {ADDR_W{1'b0}};
            start_q     <= {IDX_W{1'b0}};
            cnt_q       <= {IDX_W{1'b0}};
            mem_word    <= {WORD_W{1'b0}};
            word_idx    <= {IDX_W{1'b0}};
            word_ready  <= 1'b0;
            refill_done <= 1'b0;
            busy        <= 1'b0;
            ram_req     <= 1'b0;
            ram_addr    <= {ADDR_W{1'b0}};
        end else begin
            word_ready  <= 1'b0;
            refill_done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (miss_req) begin
                        base_q   <= miss_base_s;
                        start_q  <= miss_start_s;
                        cnt_q    <= {IDX_W{1'b0}};
                        ram_req  <= 1'b1;
                        ram_addr <= word_addr(miss_base_s, miss_start_s);
                        busy     <= 1'b1;
                        state_q  <= S_REQ;
                    end else begin
                        ram_req  <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                S_REQ: begin
                    // ram_rvalid is deliberately ignored until the grant.
                    if (ram_gnt) begin
                        ram_req <= 1'b0;
                        state_q <= S_WAIT;
                    end else begin
                        ram_req <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (ram_rvalid) begin
                        mem_word   <= ram_rdata;
                        word_idx   <= cur_idx_s;
                        word_ready <= 1'b1;
                        cnt_q      <= cnt_d;
                        if (cnt_q == LAST_CNT) begin
                            refill_done <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            ram_req  <= 1'b1;
                            ram_addr <= word_addr(base_q, next_idx_s);
                            state_q  <= S_REQ;
                        end
                    end else begin
                        ram_req <= 1'b0;
                    end
                end
                S_DONE: begin
                    // The controller's miss flag may still be high for a
                    // cycle or more; park in HOLD rather than re-accept it.
                    if (!miss_req) begin
                        busy    <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!miss_req) begin
                        busy    <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_HOLD;
                    end
                end
                default: begin
                    ram_req <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_refill_bridge.sv
// Randomized self-checking bench for imem_refill_bridge. A cycle-stepped RAM
// responder with random grant/data latency drives the bridge; expected
// addresses, indices and data are derived arithmetically from the miss
// address (critical word first, wrap inside the line).
module tb_imem_refill_bridge;

    localparam int AW = 32;
    localparam int WW = 32;
    localparam int LW = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          nrst = 1'b1;
    logic          miss_req = 1'b0;
    logic [AW-1:0] miss_addr = '0;
    logic [WW-1:0] mem_word;
    logic          word_ready;
    logic [IW-1:0] word_idx;
    logic          refill_done;
    logic          busy;
    logic          ram_req;
    logic [AW-1:0] ram_addr;
    logic          ram_gnt = 1'b0;
    logic [WW-1:0] ram_rdata = '0;
    logic          ram_rvalid = 1'b0;

    int checks = 0;
    int errors = 0;

    imem_refill_bridge #(.ADDR_W(AW), .WORD_W(WW), .LINE_WORDS(LW)) dut (
        .clk(clk), .nrst(nrst), .miss_req(miss_req), .miss_addr(miss_addr),
        .mem_word(mem_word), .word_ready(word_ready), .word_idx(word_idx),
        .refill_done(refill_done), .busy(busy), .ram_req(ram_req),
        .ram_addr(ram_addr), .ram_gnt(ram_gnt), .ram_rdata(ram_rdata),
        .ram_rvalid(ram_rvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled at negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: k-th word of the refill, by plain arithmetic.
    function automatic logic [31:0] ref_idx(input logic [31:0] a, input int k);
        return ((a >> 2) + 32'(k)) % 32'(LW);
    endfunction

    function automatic logic [31:0] ref_addr(input logic [31:0] a, input int k);
        return (a & ~32'(LW * 4 - 1)) + 32'd4 * ref_idx(a, k);
    endfunction

    task automatic chk_cleared(input string tag);
        chk({tag, "_mw"},   mem_word,    32'd0);
        chk({tag, "_idx"},  word_idx,    32'd0);
        chk({tag, "_wr"},   word_ready,  32'd0);
        chk({tag, "_done"}, refill_done, 32'd0);
        chk({tag, "_busy"}, busy,        32'd0);
        chk({tag, "_req"},  ram_req,     32'd0);
        chk({tag, "_addr"}, ram_addr,    32'd0);
    endtask

    // One complete (or aborted) refill driven from IDLE at a negedge.
    task automatic run_refill(input logic [31:0] addr, input logic [31:0] dseed,
                              input int gmin, input int gmax,
                              input int rmin, input int rmax,
                              input bit stray, input int lag, input int abort_at);
        logic [31:0] a_exp;
        int d;
        miss_req  = 1'b1;
        miss_addr = addr;
        step();
        chk("acc_busy", busy, 32'd1);
        chk("acc_req", ram_req, 32'd1);
        for (int k = 0; k < LW; k++) begin
            a_exp     = ref_addr(addr, k);
            // Miss flag and address changes after acceptance must not matter.
            miss_req  = 1'($urandom_range(0, 1));
            miss_addr = $urandom;
            chk("req_addr", ram_addr, a_exp);
            chk("req_on", ram_req, 32'd1);
            d = $urandom_range(gmin, gmax);
            for (int i = 0; i < d; i++) begin
                ram_rvalid = stray ? ((i == 0) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
                ram_rdata  = $urandom;
                step();
                ram_rvalid = 1'b0;
                chk("bp_req", ram_req, 32'd1);
                chk("bp_addr", ram_addr, a_exp);
                chk("bp_wr", word_ready, 32'd0);
            end
            ram_gnt = 1'b1;
            step();
            ram_gnt = 1'b0;
            chk("gnt_req", ram_req, 32'd0);
            chk("gnt_wr", word_ready, 32'd0);
            d = $urandom_range(rmin, rmax);
            for (int i = 0; i < d; i++) begin
                step();
                chk("wait_wr", word_ready, 32'd0);
                chk("wait_req", ram_req, 32'd0);
            end
            ram_rvalid = 1'b1;
            ram_rdata  = dseed + 32'(k);
            step();
            ram_rvalid = 1'b0;
            chk("wr", word_ready, 32'd1);
            chk("data", mem_word, dseed + 32'(k));
            chk("idx", word_idx, ref_idx(addr, k));
            chk("done", refill_done, (k == LW - 1) ? 32'd1 : 32'd0);
            chk("next_req", ram_req, (k == LW - 1) ? 32'd0 : 32'd1);
            if (k + 1 == abort_at) begin
                #2 nrst = 1'b0;
                #1 chk_cleared("abort");
                @(negedge clk);
                nrst       = 1'b1;
                miss_req   = 1'b0;
                ram_rvalid = 1'b1;
                ram_rdata  = $urandom;
                step();
                ram_rvalid = 1'b0;
                chk("late_wr", word_ready, 32'd0);
                chk("late_busy", busy, 32'd0);
                chk("late_mw", mem_word, 32'd0);
                return;
            end
        end
        for (int i = 0; i < lag; i++) begin
            miss_req = 1'b1;
            step();
            chk("hold_busy", busy, 32'd1);
            chk("hold_req", ram_req, 32'd0);
            chk("hold_done", refill_done, 32'd0);
            chk("hold_wr", word_ready, 32'd0);
        end
        miss_req = 1'b0;
        step();
        chk("end_busy", busy, 32'd0);
        chk("end_req", ram_req, 32'd0);
        chk("end_done", refill_done, 32'd0);
        chk("end_wr", word_ready, 32'd0);
    endtask

    initial begin
        // Asynchronous reset between clock edges.
        #1 nrst = 1'b0;
        #1 chk_cleared("rst");
        @(negedge clk);
        nrst = 1'b1;
        step();
        chk_cleared("post_rst");

        // Aligned line.
        run_refill(32'h100, 32'hA0, 0, 0, 0, 0, 1'b0, 0, 0);
        // Wrap-around from a mid-line byte address.
        run_refill(32'h20B, 32'hB0, 0, 0, 0, 0, 1'b0, 0, 0);
        // Back-pressure with stray rvalid during REQ.
        run_refill(32'h404, 32'hC0, 5, 5, 3, 3, 1'b1, 0, 0);
        // Miss flag lag after done, then a fresh miss.
        run_refill(32'h500, 32'hD0, 0, 1, 0, 1, 1'b0, 2, 0);
        run_refill(32'h300, 32'hE0, 0, 0, 0, 0, 1'b0, 0, 0);
        // Reset after the 2nd word, then a clean restart.
        run_refill(32'h608, 32'hF0, 0, 2, 0, 2, 1'b0, 0, 2);
        run_refill(32'h608, 32'h70, 0, 0, 0, 0, 1'b0, 0, 0);

        // Randomized refills.
        for (int n = 0; n < 25; n++) begin
            run_refill($urandom, $urandom, 0, 3, 0, 3, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 2), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_refill_bridge.md
# imem_refill_bridge

Instruction-side refill engine between the fetch unit's instruction cache controller and main RAM. On a cache miss it fetches the full cache line containing the missing address, critical word first with wrap-around, through a request/grant/valid RAM handshake. It returns each word to the cache controller as a one-cycle `word_ready` pulse, together with the word's index in the line.

## Interface
Parameters:
- ADDR_W, 32, byte-address width; matches the fetch unit PC width.
- WORD_W, 32, RAM word width; matches the cache controller memory word.
- LINE_WORDS, 4, words per cache line; must be a power of two and at least 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- nrst  in  1  asynchronous, active-low reset.
- miss_req  in  1  cache controller miss flag; level-sensitive.
- miss_addr  in  ADDR_W  missing byte address; sampled only on miss acceptance.
- mem_word  out  WORD_W  returned line word; valid only while `word_ready`=1.
- word_ready  out  1  one-cycle pulse per returned word.
- word_idx  out  log2(LINE_WORDS)  index of `mem_word` within the line.
- refill_done  out  1  one-cycle pulse after the last word of the line.
- busy  out  1  high in every state except IDLE.
- ram_req  out  1  RAM read request.
- ram_addr  out  ADDR_W  word-aligned RAM read address.
- ram_gnt  in  1  RAM accepts the request in this cycle.
- ram_rdata  in  WORD_W  RAM read data.
- ram_rvalid  in  1  `ram_rdata` is valid in this cycle.

## Operation
- OFF = log2(LINE_WORDS*4) byte-offset bits per line.
- Line base = `miss_addr` with the low OFF bits cleared.
- Start index = `miss_addr[OFF-1:2]`.
- Word address = base + 4*((start + cnt) mod LINE_WORDS). The wrap is a modulo on the index only; the upper address bits never change during a refill.
- `cnt` counts words returned, from 0 to LINE_WORDS-1.

FSM states and transitions:
- IDLE
  - Outputs: `busy`=0, `ram_req`=0.
  - If `miss_req`=1: latch base and start, clear `cnt`, go to REQ.
- REQ
  - Outputs: `ram_req`=1, `ram_addr` = current word address.
  - `ram_req` and `ram_addr` stay stable until `ram_gnt`.
  - On `ram_gnt`=1: go to WAIT.
  - `ram_rvalid` is ignored in this state.
- WAIT
  - Output: `ram_req`=0.
  - On `ram_rvalid`=1: register `ram_rdata` into `mem_word`, register the index into `word_idx`, pulse `word_ready` next cycle, and increment `cnt`.
  - If that word was number LINE_WORDS-1, go to DONE; otherwise go to REQ.
- DONE
  - `refill_done`=1 for exactly one cycle.
  - If `miss_req`=0 next: go to IDLE.
  - Otherwise go to HOLD. The controller's miss flag may lag by a cycle.
- HOLD
  - Stay until `miss_req`=0, then go to IDLE.
  - A new miss needs at least one cycle of `miss_req`=0.

Further rules:
- Only one RAM read is outstanding at a time.
- `miss_req` falling during REQ or WAIT does not abort; the line always completes.
- `miss_addr` changes after acceptance are ignored.

## Timing
- Reset values, applied immediately while `nrst`=0 (asynchronous) and held until its release:
  - state = IDLE
  - `mem_word`=0, `word_idx`=0
  - `word_ready`=0, `refill_done`=0
  - `busy`=0, `ram_req`=0, `ram_addr`=0
  - `cnt`=0, base=0, start=0
- Reset mid-refill drops any outstanding RAM read; a later `ram_rvalid` in IDLE is ignored.
- Miss acceptance to first `ram_req`: 1 cycle (`miss_req` sampled at edge N, `ram_req`=1 from N+1).
- `ram_gnt` at edge G: WAIT from G+1. The earliest usable `ram_rvalid` is sampled at edge G+1.
- `ram_rvalid` at edge V: `word_ready`, `mem_word`, `word_idx` valid in cycle V+1. Next `ram_req` is also asserted in cycle V+1 (REQ).
- Last word: `word_ready` and `refill_done` are asserted in the same cycle.
- With zero-wait RAM (gnt in the REQ cycle, rvalid in the next cycle), each word takes 2 cycles. A line takes 2*LINE_WORDS cycles, plus 1 cycle of acceptance.
- `word_ready` is never high on two consecutive cycles.

## Test plan
- Reset: pulse `nrst` low asynchronously between edges -> all outputs 0 immediately, state IDLE.
- Aligned miss: `miss_addr`=0x100, RAM returns 0xA0..0xA3, gnt same cycle, rvalid next cycle.
  - `ram_addr` = 0x100, 0x104, 0x108, 0x10C.
  - `word_idx` = 0,1,2,3 with matching data.
  - `refill_done` on the 4th `word_ready`.
- Wrap-around: `miss_addr`=0x20B.
  - `ram_addr` = 0x208, 0x20C, 0x200, 0x204.
  - `word_idx` = 2,3,0,1.
  - `ram_addr` never reaches 0x210.
- Back-pressure: hold `ram_gnt`=0 for 5 cycles, then delay `ram_rvalid` by 3 cycles.
  - `ram_req` and `ram_addr` stable throughout.
  - Exactly one `word_ready` per word.
  - A stray `ram_rvalid` during REQ is ignored.
- Miss flag lag: keep `miss_req`=1 two cycles after `refill_done`.
  - Bridge sits in HOLD with no new `ram_req`.
  - After `miss_req`=0 for one cycle, a new miss at 0x300 starts a refill at 0x300.
- Reset mid-refill: assert `nrst`=0 after the 2nd word.
  - Outputs cleared.
  - A late `ram_rvalid` after release produces no `word_ready`.
  - The next miss restarts cleanly with `cnt`=0.
